psu_on_seq_ctrl: RTL

- PSU power-on sequencer FSM for the PSU-on control stage.
- On a platform power-enable request, it asserts PS_ON and waits for PSU PWROK, bounded by a timeout.
- It then requires PWROK to stay stable for a qualification window before reporting power good.
- It sequences an orderly shutdown on request, or latches a fault with a cause code. Its single internal timer is referenced to the 2 MHz clock.

---
 rtl/psu_on_seq_ctrl_if.sv | 34 +++
 rtl/psu_on_seq_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/psu_on_seq_ctrl_if.sv
// Platform/PSU signal bundle for the PSU-on sequencer.
// The slave modport is the sequencer side; the master modport is the platform/PSU side.
interface psu_on_seq_ctrl_if;
  logic       iPwrEn;
  logic       iPsuPwrOk;
  logic       iFaultClr;
  logic       oPsOn;
  logic       oPwrGood;
  logic       oFault;
  logic [1:0] oFaultCode;
  logic [2:0] oState;

  modport slave (
    input  iPwrEn,
    input  iPsuPwrOk,
    input  iFaultClr,
    output oPsOn,
    output oPwrGood,
    output oFault,
    output oFaultCode,
    output oState
  );

  modport master (
    output iPwrEn,
    output iPsuPwrOk,
    output iFaultClr,
    input  oPsOn,
    input  oPwrGood,
    input  oFault,
    input  oFaultCode,
    input  oState
  );
endinterface

// File: rtl/psu_on_seq_ctrl.sv
// PSU power-on sequencer: drives PS_ON, qualifies PWROK over a stability window,
// sequences shutdown with a minimum off dwell, and latches faults with a cause code.
module psu_on_seq_ctrl #(
  parameter int CNT_W      = 21,
  parameter int T_PWROK_TO = 2000000,
  parameter int T_STABLE   = 100000,
  parameter int T_OFF_DLY  = 100000
) (
  input  logic                iClk,
  input  logic                iRst,
  psu_on_seq_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_OK  = 3'd1,
    ST_STABLE   = 3'd2,
    ST_ON       = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_STABLE  = 2'b10;
  localparam logic [1:0] CODE_ON      = 2'b11;

  // Windows elapse when the last cycle index (T-1) is sampled.
  localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(T_PWROK_TO - 1);
  localparam logic [CNT_W-1:0] LP_STB_LAST = CNT_W'(T_STABLE - 1);
  localparam logic [CNT_W-1:0] LP_OFF_LAST = CNT_W'(T_OFF_DLY - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_ps_on;
  logic             r_pwr_good;
  logic             r_fault;
  logic [1:0]       r_code;

  state_t           w_nxt_state;
  logic [1:0]       w_nxt_code;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_code  = CODE_NONE;
    case (r_state)
      ST_OFF: begin
        if (bus.iPwrEn) w_nxt_state = ST_WAIT_OK;
      end
      ST_WAIT_OK: begin
        if (!bus.iPwrEn) begin
          w_nxt_state = ST_SHUTDOWN;
        end else if (bus.iPsuPwrOk) begin
          w_nxt_state = ST_STABLE;
        end else if (r_timer == LP_TO_LAST) begin
          w_nxt_state = ST_FAULT;
          w_nxt_code  = CODE_TIMEOUT;
        end
      end
      ST_STABLE: begin
        if (!bus.iPwrEn) begin
          w_nxt_state = ST_SHUTDOWN;
        end else if (!bus.iPsuPwrOk) begin
          w_nxt_state = ST_FAULT;
          w_nxt_code  = CODE_STABLE;
        end else if (r_timer == LP_STB_LAST) begin
          w_nxt_state = ST_ON;
        end
      end
      ST_ON: begin
        // Commanded off outranks a simultaneous PWROK loss.
        if (!bus.iPwrEn) begin
          w_nxt_state = ST_SHUTDOWN;
        end else if (!bus.iPsuPwrOk) begin
          w_nxt_state = ST_FAULT;
          w_nxt_code  = CODE_ON;
        end
      end
      ST_SHUTDOWN: begin
        if (r_timer == LP_OFF_LAST) w_nxt_state = ST_OFF;
      end
      ST_FAULT: begin
        w_nxt_code = r_code;
        if (bus.iFaultClr && !bus.iPwrEn) begin
          w_nxt_state = ST_OFF;
          w_nxt_code  = CODE_NONE;
        end
      end
      default: begin
        w_nxt_state = ST_OFF;
        w_nxt_code  = CODE_NONE;
      end
    endcase
  end

  // State, timer and decoded outputs all update on the same edge.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= ST_OFF;
      r_timer    <= '0;
      r_ps_on    <= 1'b0;
      r_pwr_good <= 1'b0;
      r_fault    <= 1'b0;
      r_code     <= CODE_NONE;
    end else begin
      r_state <= w_nxt_state;
      if (w_nxt_state != r_state) begin
        r_timer <= '0;
      end else if (r_timer != LP_CNT_MAX) begin
        r_timer <= r_timer + 1'b1;
      end
      r_ps_on    <= (w_nxt_state == ST_WAIT_OK) || (w_nxt_state == ST_STABLE) ||
                    (w_nxt_state == ST_ON);
      r_pwr_good <= (w_nxt_state == ST_ON);
      r_fault    <= (w_nxt_state == ST_FAULT);
      r_code     <= w_nxt_code;
    end
  end

  assign bus.oPsOn      = r_ps_on;
  assign bus.oPwrGood   = r_pwr_good;
  assign bus.oFault     = r_fault;
  assign bus.oFaultCode = r_code;
  assign bus.oState     = r_state;

endmodule
